// File: rtl/rgb_pwm_pkg.sv
// Shared types for the RGB PWM output stage: FSM states, duty triple and the
// gamma curve applied at capture when RGB_PWM_GAMMA_EN is defined.
package rgb_pwm_pkg;

    // Duty storage is sized for the widest supported PWM_BITS; narrower
    // configurations keep the upper bits at zero.
    localparam int unsigned DUTY_MAX_W = 16;

    typedef logic [DUTY_MAX_W-1:0] duty_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pwm_state_t;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_duty_t;

    // Squared brightness curve, g = d*d >> bits, with full scale kept at full scale.
    function automatic duty_t gamma_correct(input duty_t d, input int unsigned bits);
        logic [2*DUTY_MAX_W-1:0] prod;
        logic [2*DUTY_MAX_W-1:0] full;
        full = (32'd1 << bits) - 32'd1;
        prod = {{DUTY_MAX_W{1'b0}}, d} * {{DUTY_MAX_W{1'b0}}, d};
        if ({{DUTY_MAX_W{1'b0}}, d} == full) begin
            return d;
        end
        return duty_t'(prod >> bits);
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM output: compares the shared period counter with this channel's
// active duty and registers the pin at the configured LED-on polarity.
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    input  duty_t cnt_i,
    input  duty_t duty_i,
    output logic  pin_o
);

    localparam logic PIN_OFF = ACTIVE_LOW;

    logic pin_q;
    logic pin_d;

    // Strict less-than: duty 0 never lights, the top code misses one tick.
    always_comb begin
        pin_d = (cnt_i < duty_i) ? ~PIN_OFF : PIN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_q <= PIN_OFF;
        end else begin
            pin_q <= pin_d;
        end
    end

    assign pin_o = pin_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: prescaled period counter, double-buffered duty triple
// swapped on period boundaries, three registered pin drivers.
// Optional gamma correction on capture is enabled by defining RGB_PWM_GAMMA_EN.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRESCALE   = 46,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    input  logic                duty_valid,
    output logic                duty_ready,
    output logic                period_start,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);

    localparam int unsigned         PRE_W    = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PRE_W-1:0]    PRE_TERM = PRE_W'(PRESCALE);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

    logic [PRE_W-1:0]    pre_cnt_q;
    logic [PRE_W-1:0]    pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic                tick;
    logic                boundary;

    pwm_state_t state_q;
    rgb_duty_t  pending_q;
    rgb_duty_t  active_q;
    rgb_duty_t  captured;
    logic       duty_ready_q;
    logic       period_start_q;
    logic       xfer;

    assign tick     = (pre_cnt_q == PRE_TERM);
    assign boundary = tick && (pwm_cnt_q == CNT_MAX);

    always_comb begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    always_comb begin
        captured.r = duty_t'(duty_r);
        captured.g = duty_t'(duty_g);
        captured.b = duty_t'(duty_b);
`ifdef RGB_PWM_GAMMA_EN
        captured.r = gamma_correct(captured.r, PWM_BITS);
        captured.g = gamma_correct(captured.g, PWM_BITS);
        captured.b = gamma_correct(captured.b, PWM_BITS);
`endif
    end

    // Handshake: a triple moves when duty_valid && duty_ready are both high at
    // a rising clk edge; valid may stay high and is simply ignored while not ready.
    assign xfer = duty_valid && duty_ready_q;

    // Pending is promoted only on a boundary, so a capture landing on the
    // boundary cycle itself waits a whole period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            active_q       <= '0;
            duty_ready_q   <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= boundary;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        pending_q    <= captured;
                        state_q      <= PENDING;
                        duty_ready_q <= 1'b0;
                    end else begin
                        duty_ready_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (boundary) begin
                        active_q     <= pending_q;
                        state_q      <= IDLE;
                        duty_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    duty_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign duty_ready   = duty_ready_q;
    assign period_start = period_start_q;

    duty_t cnt_ext;
    assign cnt_ext = duty_t'(pwm_cnt_q);

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_chan_r (
        .clk    (clk),
        .reset  (reset),
        .cnt_i  (cnt_ext),
        .duty_i (active_q.r),
        .pin_o  (RGB_R)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_chan_g (
        .clk    (clk),
        .reset  (reset),
        .cnt_i  (cnt_ext),
        .duty_i (active_q.g),
        .pin_o  (RGB_G)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .cnt_i  (cnt_ext),
        .duty_i (active_q.b),
        .pin_o  (RGB_B)
    );

endmodule
